// File: rtl/inst_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder: format and
// error-cause enums, base opcodes, and immediate range limits.
package inst_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4
    } fmt_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_FMT   = 2'd1,
        ERR_RANGE = 2'd2,
        ERR_ALIGN = 2'd3
    } err_code_t;

    // Base opcodes, shared with the decoder side.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Signed immediate limits for I/S (12-bit) and B (13-bit, even).
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;

    // True when the sign-extended immediate lies within [lo, hi].
    function automatic logic imm_in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// Two-entry FIFO holding {instruction, address} pairs for the
// instruction-memory write port. Head is visible on 'head' while not empty.
module inst_enc_fifo #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy update on push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is reset because the head is an output that must read 0 out of reset.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_enc.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word,
// tags it with an auto-incrementing byte address and queues it for the
// instruction-memory write port. Legality checks are compiled in when
// INST_ENC_CHECK_EN is defined; otherwise fields are bit-selected as-is.
module inst_enc
    import inst_enc_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_inm,
    input  logic                 addr_load,
    input  logic [ADDR_W-1:0]    addr_base,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int ENTRY_W = 32 + ADDR_W;

    logic              accept;
    logic              rejected;
    logic              legal_push;
    logic [31:0]       enc_word;
    err_code_t         rej_code;
    err_code_t         err_code_q;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] word_addr;
    logic [ENTRY_W-1:0] fifo_head;
    logic [1:0]        fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // Readiness comes from the registered occupancy only; a pop this cycle
    // frees a slot for the next cycle, never the current one.
    assign in_ready   = !rst && (fifo_count < 2'd2);
    assign accept     = in_valid && in_ready;
    assign rejected   = accept && (rej_code != ERR_NONE);
    assign legal_push = accept && (rej_code == ERR_NONE) && !fifo_full;

    // An address load on the same edge redirects the word being accepted.
    assign word_addr = addr_load ? addr_base : addr_cnt;

    // Field packing per format; unknown formats fall back to R layout.
    always_comb begin
        // NOTE: default assigned first so every path writes enc_word and no latch is inferred.
        enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        case (in_fmt)
            FMT_I:   enc_word = {in_inm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S:   enc_word = {in_inm[11:5], in_rs2, in_rs1, in_funct3, in_inm[4:0], in_opcode};
            FMT_B:   enc_word = {in_inm[12], in_inm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_inm[4:1], in_inm[11], in_opcode};
            FMT_U:   enc_word = {in_inm[31:12], in_rd, in_opcode};
            default: ;
        endcase
    end

    // Legality of the presented request; range failures outrank alignment.
    always_comb begin
        rej_code = ERR_NONE;
`ifdef INST_ENC_CHECK_EN
        case (in_fmt)
            FMT_R: rej_code = ERR_NONE;
            FMT_I, FMT_S: begin
                if (!imm_in_range(in_inm, IMM12_MIN, IMM12_MAX)) rej_code = ERR_RANGE;
            end
            FMT_B: begin
                if (!imm_in_range(in_inm, IMM_B_MIN, IMM_B_MAX)) rej_code = ERR_RANGE;
                else if (in_inm[0])                              rej_code = ERR_ALIGN;
            end
            FMT_U: begin
                if (in_inm[11:0] != 12'd0) rej_code = ERR_ALIGN;
            end
            default: rej_code = ERR_FMT;
        endcase
`endif
    end

    // Word address counter: advances past each pushed word, or takes a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
            addr_cnt <= '0;
        end else if (legal_push) begin
            addr_cnt <= word_addr + ADDR_W'(4);
        end else if (addr_load) begin
            addr_cnt <= addr_base;
        end
    end

    // Rejection reporting: one-cycle pulse, sticky cause, saturating count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err        <= 1'b0;
            err_code_q <= ERR_NONE;
            err_cnt    <= '0;
        end else begin
            err <= rejected;
            if (rejected) begin
                err_code_q <= rej_code;
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign err_code = err_code_q;

    inst_enc_fifo #(.W(ENTRY_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (legal_push),
        .push_data ({enc_word, word_addr}),
        .pop       (out_valid && out_ready),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_inst  = fifo_head[ENTRY_W-1:ADDR_W];
    assign out_addr  = fifo_head[ADDR_W-1:0];

endmodule

// File: tb/tb_inst_enc.sv
// Self-checking bench for inst_enc: a queue-based reference model checked
// every cycle, directed vectors with hand-computed words, a random
// round-trip phase through a reference immediate decoder, reset and
// error-counter saturation. Expectations adapt to INST_ENC_CHECK_EN.
module tb_inst_enc;

    localparam int ADDR_W    = 32;
    localparam int ERR_CNT_W = 8;
`ifdef INST_ENC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_fmt;
    logic [6:0]           in_opcode;
    logic [4:0]           in_rd, in_rs1, in_rs2;
    logic [2:0]           in_funct3;
    logic [6:0]           in_funct7;
    logic [31:0]          in_inm;
    logic                 addr_load;
    logic [ADDR_W-1:0]    addr_base;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_inst;
    logic [ADDR_W-1:0]    out_addr;
    logic                 err;
    logic [1:0]           err_code;
    logic [ERR_CNT_W-1:0] err_cnt;

    inst_enc #(.ADDR_W(ADDR_W), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_inm(in_inm),
        .addr_load(addr_load), .addr_base(addr_base),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr),
        .err(err), .err_code(err_code), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [2:0]  fmt;
        logic [31:0] inm;
        bit          legal;
    } entry_t;

    entry_t      q[$];
    logic [31:0] m_addr    = 32'd0;
    bit          m_err     = 1'b0;
    logic [1:0]  m_code    = 2'd0;
    int          m_cnt     = 0;
    int          m_accepts = 0;

    function automatic logic [1:0] legality(input logic [2:0] f, input logic [31:0] inm);
        int v;
        v = $signed(inm);
        case (f)
            3'd0:       return 2'd0;
            3'd1, 3'd2: return (v < -2048 || v > 2047) ? 2'd2 : 2'd0;
            3'd3: begin
                if (v < -4096 || v > 4094) return 2'd2;
                if (v % 2 != 0)            return 2'd3;
                return 2'd0;
            end
            3'd4:       return (inm % 4096 != 0) ? 2'd3 : 2'd0;
            default:    return 2'd1;
        endcase
    endfunction

    function automatic logic [31:0] encode(input logic [2:0] f, input logic [6:0] op,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] inm);
        logic [31:0] regs;
        regs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (f)
            3'd1: return regs | ((inm & 32'hFFF) << 20) | (32'(rd) << 7);
            3'd2: return regs | (((inm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20)
                              | ((inm & 32'h1F) << 7);
            3'd3: return regs | (((inm >> 12) & 32'h1) << 31) | (((inm >> 5) & 32'h3F) << 25)
                              | (32'(rs2) << 20) | (((inm >> 1) & 32'hF) << 8)
                              | (((inm >> 11) & 32'h1) << 7);
            3'd4: return (inm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
            default: return regs | (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rd) << 7);
        endcase
    endfunction

    // Reference immediate generator (decoder side).
    function automatic logic [31:0] imm_gen(input logic [31:0] i, input logic [2:0] f);
        case (f)
            3'd1:    return {{20{i[31]}}, i[31:20]};
            3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {i[31:12], 12'd0};
        endcase
    endfunction

    // Model step on each rising edge; cleared asynchronously by reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_addr = 32'd0;
            m_err  = 1'b0;
            m_code = 2'd0;
            m_cnt  = 0;
        end else begin : step
            bit          acc;
            bit          pop;
            logic [1:0]  code;
            logic [31:0] base;
            entry_t      e;
            acc   = in_valid && (q.size() < 2);
            pop   = (q.size() > 0) && out_ready;
            base  = addr_load ? addr_base : m_addr;
            code  = CHK ? legality(in_fmt, in_inm) : 2'd0;
            m_err = 1'b0;
            if (pop) void'(q.pop_front());
            if (acc && code == 2'd0) begin
                e.inst  = encode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_inm);
                e.addr  = base;
                e.fmt   = in_fmt;
                e.inm   = in_inm;
                e.legal = (legality(in_fmt, in_inm) == 2'd0);
                q.push_back(e);
                m_addr = base + 32'd4;
                m_accepts++;
            end else begin
                if (acc) begin
                    m_err  = 1'b1;
                    m_code = code;
                    if (m_cnt < 255) m_cnt++;
                end
                if (addr_load) m_addr = addr_base;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", in_ready, q.size() < 2);
            check("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                check("out_inst", out_inst, q[0].inst);
                check("out_addr", out_addr, q[0].addr);
                if (q[0].legal && q[0].fmt >= 3'd1 && q[0].fmt <= 3'd4)
                    check("round_trip", imm_gen(out_inst, q[0].fmt), q[0].inm);
            end
            check("err", err, m_err);
            check("err_code", err_code, m_code);
            check("err_cnt", err_cnt, m_cnt[7:0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] inm);
        in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_inm = inm;
    endtask

    // Present one request and hold it until the edge that accepts it.
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] inm);
        int b;
        set_req(f, op, rd, rs1, rs2, f3, f7, inm);
        in_valid = 1'b1;
        b = 0;
        while (!in_ready && b < 50) begin
            cycle();
            b++;
        end
        check("send_ready", in_ready, 1'b1);
        cycle();
        in_valid  = 1'b0;
        addr_load = 1'b0;
    endtask

    task automatic gen_legal();
        logic [2:0]  f;
        logic [31:0] r;
        f = 3'($urandom_range(0, 4));
        r = $urandom;
        case (f)
            3'd0: set_req(f, 7'b0110011, r[4:0], r[9:5], r[14:10], r[17:15], r[24:18], 32'd0);
            3'd1: set_req(f, r[0] ? 7'b0010011 : 7'b0000011, r[4:0], r[9:5], 5'd0, r[17:15], 7'd0,
                          32'($urandom_range(0, 4095)) - 32'd2048);
            3'd2: set_req(f, 7'b0100011, 5'd0, r[9:5], r[14:10], r[17:15], 7'd0,
                          32'($urandom_range(0, 4095)) - 32'd2048);
            3'd3: set_req(f, 7'b1100011, 5'd0, r[9:5], r[14:10], r[17:15], 7'd0,
                          (32'($urandom_range(0, 4095)) << 1) - 32'd4096);
            default: set_req(f, r[0] ? 7'b0110111 : 7'b0010111, r[4:0], 5'd0, 5'd0, 3'd0, 7'd0,
                             {$urandom_range(0, 32'hFFFFF), 12'd0} & 32'hFFFFF000);
        endcase
    endtask

    initial begin : main
        int start;
        int budget;
        bit will_acc;

        in_valid = 1'b0; addr_load = 1'b0; addr_base = '0; out_ready = 1'b1;
        set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

        // Reset state while rst is held.
        #3;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        check("rst_err", err, 1'b0);
        check("rst_err_code", err_code, 2'd0);
        check("rst_err_cnt", err_cnt, 8'd0);
        cycle(); cycle();
        rst = 1'b0;
        cycle();

        // ADDI x5,x1,-1 with address load 0x100 on the same edge.
        addr_load = 1'b1; addr_base = 32'h100;
        send(3'd1, 7'b0010011, 5'd5, 5'd1, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        check("addi_valid", out_valid, 1'b1);
        check("addi_inst", out_inst, 32'hFFF08293);
        check("addi_addr", out_addr, 32'h100);

        // BEQ x1,x2,+8, pushed as the ADDI is popped.
        send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        check("beq_inst", out_inst, 32'h00208463);
        check("beq_addr", out_addr, 32'h104);

        // BEQ with odd offset.
        send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd9);
        check("beq9_err", err, CHK ? 1'b1 : 1'b0);
        check("beq9_code", err_code, CHK ? 2'd3 : 2'd0);
        check("beq9_cnt", err_cnt, CHK ? 8'd1 : 8'd0);
        check("beq9_valid", out_valid, CHK ? 1'b0 : 1'b1);

        // LUI x3,0x12345000; counter untouched by the rejection.
        send(3'd4, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        check("lui_inst", out_inst, 32'h123451B7);
        check("lui_addr", out_addr, CHK ? 32'h108 : 32'h10C);
        check("lui_err", err, 1'b0);

        send(3'd4, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
        check("lui_bad_code", err_code, CHK ? 2'd3 : 2'd0);
        check("lui_bad_cnt", err_cnt, CHK ? 8'd2 : 8'd0);

        send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd2048);
        check("s2048_code", err_code, CHK ? 2'd2 : 2'd0);
        check("s2048_cnt", err_cnt, CHK ? 8'd3 : 8'd0);
        cycle();
        check("err_pulse_end", err, 1'b0);
        cycle();

        // Backpressure: two accepted, third stalls until a pop frees a slot.
        out_ready = 1'b0;
        addr_load = 1'b1; addr_base = 32'h200;
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        send(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        set_req(3'd1, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        in_valid = 1'b1;
        check("bp_full_ready", in_ready, 1'b0);
        check("bp_head_inst", out_inst, 32'h00100093);
        check("bp_head_addr", out_addr, 32'h200);
        out_ready = 1'b1;
        cycle();
        check("bp_pop1_inst", out_inst, 32'h00200113);
        check("bp_pop1_addr", out_addr, 32'h204);
        check("bp_pop1_ready", in_ready, 1'b1);
        cycle();
        in_valid = 1'b0;
        check("bp_third_inst", out_inst, 32'h00300193);
        check("bp_third_addr", out_addr, 32'h208);
        cycle();
        check("bp_drained", out_valid, 1'b0);

        // Random legal traffic with random backpressure.
        start  = m_accepts;
        budget = 0;
        gen_legal();
        while (m_accepts - start < 1000 && budget < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            will_acc  = in_valid && in_ready;
            cycle();
            budget++;
            if (will_acc) gen_legal();
        end
        check("random_done", (m_accepts - start) >= 1000, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1;
        cycle(); cycle(); cycle();

        // Mid-operation reset with two words queued.
        out_ready = 1'b0;
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        send(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        check("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_ready", in_ready, 1'b0);
        check("mid_rst_err_cnt", err_cnt, 8'd0);
        check("mid_rst_addr", out_addr, 32'd0);
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        cycle();
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        check("post_rst_addr", out_addr, 32'd0);
        check("post_rst_inst", out_inst, 32'h00100093);

        // Error counter saturation with a stream of bad-format requests.
        set_req(3'd5, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        repeat (260) cycle();
        in_valid = 1'b0;
        cycle();
        check("sat_err_cnt", err_cnt, CHK ? 8'd255 : 8'd0);
        check("sat_err_code", err_code, CHK ? 2'd1 : 2'd0);
        cycle(); cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_enc.md
Name: inst_enc

Overview:
- Instruction encoder: the inverse of the core's immediate generator. Takes decoded fields (format, opcode, rd, rs1, rs2, funct3, funct7, immediate) and packs them into a 32-bit RV32I word.
- Sits between the self-test/program-loader sequencer and the instruction-memory write port.
- Valid/ready input, 2-entry output FIFO, and an auto-incrementing word address.
- Immediate input uses the same representation the immediate generator produces, so decode(encode(x)) round-trips.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address
- ERR_CNT_W, 8, width of the saturating rejected-request counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  request present
- in_ready  out  1  request can be accepted
- in_fmt  in  3  fmt_t: R=0, I=1, S=2, B=3, U=4; 5..7 illegal
- in_opcode  in  7  opcode field
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R-type only)
- in_inm  in  32  immediate, sign-extended value as produced by the immediate generator
- addr_load  in  1  load address counter
- addr_base  in  ADDR_W  value for addr_load
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer takes word
- out_inst  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address for out_inst
- err  out  1  one-cycle pulse: request rejected
- err_code  out  2  last rejection cause: 0 none, 1 bad fmt, 2 range, 3 alignment
- err_cnt  out  ERR_CNT_W  saturating count of rejected requests

Behaviour:
- Reset (async, rst=1): FIFO empty, out_valid=0, out_inst=0, out_addr=0, address counter=0, err=0, err_code=0, err_cnt=0, in_ready=0 while rst asserted.
- Accept: in_valid && in_ready on a rising edge. in_ready = FIFO count < 2, registered-derived.
- No same-cycle bypass: a pop from a full FIFO raises in_ready the next cycle.
- Encoding, combinational at accept:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {inm[11:0], rs1, funct3, rd, opcode}
  - S: {inm[11:5], rs2, rs1, funct3, inm[4:0], opcode}
  - B: {inm[12], inm[10:5], rs2, rs1, funct3, inm[4:1], inm[11], opcode}
  - U: {inm[31:12], rd, opcode}
- Legality checks:
  - fmt > 4 -> reject, code 1.
  - I/S: inm outside -2048..2047 -> reject, code 2.
  - B: inm outside -4096..4094 -> reject, code 2; inm[0]=1 -> reject, code 3.
  - U: inm[11:0] != 0 -> reject, code 3.
  - When both range and alignment fail, code 2 wins.
- Legal accept: word plus current counter value pushed into FIFO; counter += 4.
  - Counter wraps modulo 2^ADDR_W without flag.
- Rejected accept: nothing pushed, counter unchanged, err=1 for exactly the next cycle, err_code updated (sticky until next rejection or reset), err_cnt += 1 saturating at all-ones.
- Latency: legal accept at edge k -> out_valid=1 after edge k (visible cycle k+1) if FIFO was empty.
- out_inst/out_addr show FIFO head; stable while out_valid && !out_ready. Pop on out_valid && out_ready.
- Simultaneous push and pop with count=1: count stays 1, order preserved.
- addr_load:
  - Loads the counter at the edge.
  - If a legal accept occurs the same edge, that word takes addr_base and the counter becomes addr_base+4.
  - If it coincides with a rejection, the counter becomes addr_base.
- Mid-operation reset discards FIFO contents and in-flight requests.

Optional Feature:
- Macro INST_ENC_CHECK_EN.
- Defined: the legality checks above are active.
- Undefined: no checks. Every accept with fmt 0..4 is encoded by silent truncation (bit-select only). fmt > 4 encodes as R-type. err, err_code, and err_cnt are tied to 0.

Decomposition:
- Package inst_enc_pkg holds:
  - fmt_t enum
  - err_code_t enum
  - RV32I opcode localparams (LOAD, OPinm, STORE, BRANCH, LUI, AUIPC, OP), shared with the decoder side
  - immediate range constants
- One sub-module: inst_enc_fifo, a 2-entry FIFO carrying {inst, addr} with count, full, and empty.
- Encoding and checking stay combinational inside inst_enc.

Test Plan:
- I-type ADDI x5,x1,-1 (fmt=1, opcode 0010011, f3=0, inm=32'hFFFFFFFF), addr_load base 0x100 same edge -> out_inst 32'hFFF08293, out_addr 0x100, out_valid one cycle later.
- B-type BEQ x1,x2,+8 (fmt=3, opcode 1100011, inm=8) -> 32'h00208463. inm=9 -> no push, err pulse, err_code 3, err_cnt 1, counter unchanged.
- Backpressure: out_ready=0, 3 legal requests -> first two accepted, in_ready=0 on third. Release out_ready -> words emitted in order with addr, addr+4; third accepted the cycle after the first pop.
- U-type LUI x3,0x12345000 -> 32'h123451B7. inm=0x12345001 -> reject, code 3. S-type inm=2048 -> reject, code 2.
- Round-trip: 1000 random legal requests. Feed out_inst to the immediate generator -> output equals in_inm for I/S/B/U; addresses strictly +4.
- Assert rst with 2 words queued -> out_valid=0 immediately (async), counter 0, err_cnt 0. Exercise err_cnt saturation (256 rejects -> 255).
